vx_mem_gbus_bridge: RTL and testbench
=====================================

VX_MEM_GBUS_BRIDGE -- requirements
Module: vx_mem_gbus_bridge

Interface
REQ-001 SHALL have parameter LINE_BITS, default 512, meaning Vortex memory line width.
REQ-002 SHALL have parameter ADDR_BITS, default 26, meaning Vortex line address width.
REQ-003 SHALL have parameter TAG_BITS, default 56, meaning Vortex memory tag width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port mem_req_valid, input, 1 bit, meaning a Vortex request is present.
REQ-007 SHALL have port mem_req_rw, input, 1 bit; 1 is a write, 0 is a read.
REQ-008 SHALL have port mem_req_byteen, input, LINE_BITS/8 bits, meaning per-byte write enables.
REQ-009 SHALL have port mem_req_addr, input, ADDR_BITS bits, meaning the line address.
REQ-010 SHALL have port mem_req_data, input, LINE_BITS bits, meaning write data.
REQ-011 SHALL have port mem_req_tag, input, TAG_BITS bits, meaning the request tag.
REQ-012 SHALL have port mem_req_ready, output, 1 bit, meaning the request is accepted.
REQ-013 SHALL have port mem_rsp_valid, output, 1 bit, meaning read data is presented.
REQ-014 SHALL have ports mem_rsp_data, output, LINE_BITS bits, and mem_rsp_tag, output, TAG_BITS bits.
REQ-015 SHALL have port mem_rsp_ready, input, 1 bit, meaning Vortex accepts the response.
REQ-016 SHALL have port gbif, a generic_bus_if.cpu modport; the bridge is the bus initiator toward a generic_bus responder.

Function
REQ-017 SHALL use the FSM states IDLE, READ, WRITE and RSP; mem_req_ready is 1 only in IDLE.
REQ-018 SHALL, in IDLE when mem_req_valid is 1, latch rw, byteen, addr, data and tag, clear the word counter, and go to WRITE if rw is 1, else READ.
REQ-019 SHALL form the word byte address as {latched addr, 6'b0} + 4*wcnt; wcnt is a 4-bit counter over words 0..15, and the address never overflows 32 bits.
REQ-020 SHALL, in READ, drive ren=1, wen=0 and byte_en=4'hF.
REQ-021 SHALL treat a bus beat as complete in a cycle where ren or wen is 1 and busy is 0.
REQ-022 SHALL, on read-beat completion, store rdata into line bits [32*wcnt +: 32], then increment wcnt.
REQ-023 SHALL, on completion of the word-15 read beat, go to RSP.
REQ-024 SHALL, in WRITE, drive wdata = word wcnt of the latched data and byte_en = byteen[4*wcnt +: 4].
REQ-025 SHALL, in WRITE with a nonzero byte_en slice, drive wen=1 and advance on completion.
REQ-026 SHALL, in WRITE with a zero byte_en slice, drive wen=0 and advance after one cycle with no bus beat.
REQ-027 SHALL, after the word-15 write step, return to IDLE; writes produce no response.
REQ-028 SHALL, in RSP, drive mem_rsp_valid=1 with the assembled line and latched tag held stable, and return to IDLE on mem_rsp_ready.
REQ-029 SHALL hold addr, wdata, byte_en, ren and wen stable while busy is 1.
REQ-030 SHALL drive ren=0 and wen=0 in IDLE and RSP.
REQ-031 SHALL accept at most one outstanding request; a new request is accepted no earlier than the cycle after the previous transaction ends.

Reset
REQ-032 SHALL, on reset assertion, immediately abort any transaction and force state to IDLE.
REQ-033 SHALL reset mem_req_ready=1, mem_rsp_valid=0, ren=0, wen=0, byte_en=0, addr=0 and wdata=0.
REQ-034 SHALL reset mem_rsp_data=0, mem_rsp_tag=0 and wcnt=0.

Structure
REQ-035 SHALL place the state enum, WORDS_PER_LINE=16 and the word-index width in a shared package, vx_gbus_bridge_pkg.
REQ-036 SHALL be a single module with no sub-module; line assembly and slicing are done inline.

Verification
REQ-037 SHALL verify a read of addr 26'h000010 with busy=0: beats at 0x400..0x43C, rdata=0xA0+i, rsp line word i = 0xA0+i, and mem_rsp_valid rising 17 cycles after acceptance.
REQ-038 SHALL verify a read with busy held 3 cycles on each beat: 64 bus cycles, bus signals stable during each busy stall, and the correct line.
REQ-039 SHALL verify a write of all-ones byteen with data word i = i: 16 wen beats of 0..15 and no mem_rsp_valid.
REQ-040 SHALL verify a write with byteen = 64'h000000000000F00F: wen only for word 0 (byte_en F) and word 3 (byte_en F), then return to IDLE after 16 steps.
REQ-041 SHALL verify mem_rsp_ready held low 5 cycles in RSP: mem_rsp_valid, data and tag stay stable, and mem_req_ready=0 throughout.
REQ-042 SHALL verify reset asserted mid-read at word 7: next edge gives IDLE, ren=0 and mem_req_ready=1, and no response is issued.

Source files
------------

// File: rtl/vx_gbus_bridge_pkg.sv
// Shared types for the Vortex memory to generic_bus bridge.
// Holds the bridge FSM state encoding, the line geometry (16 x 32-bit words)
// and a helper that turns a word index into a byte offset within the line.
package vx_gbus_bridge_pkg;

  localparam int WORDS_PER_LINE = 16;
  localparam int WIDX_BITS      = 4;

  typedef logic [WIDX_BITS-1:0] widx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RSP   = 2'd3
  } state_e;

  // Byte offset of word w within a line (4 bytes per word).
  function automatic logic [31:0] word_offset(widx_t w);
    return {{(32-WIDX_BITS-2){1'b0}}, w, 2'b00};
  endfunction

endpackage

// File: rtl/generic_bus_if.sv
// Simple 32-bit generic bus: one beat per cycle in which ren or wen is high
// and the responder drops busy.
// cpu modport: initiator drives ren/wen/addr/wdata/byte_en, samples rdata/busy.
// generic_bus modport: responder side.
interface generic_bus_if;
  logic        ren;
  logic        wen;
  logic        busy;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  byte_en;

  modport cpu (
    output ren, wen, addr, wdata, byte_en,
    input  rdata, busy
  );

  modport generic_bus (
    input  ren, wen, addr, wdata, byte_en,
    output rdata, busy
  );
endinterface

// File: rtl/vx_mem_gbus_bridge.sv
// Bridges a Vortex line-wide memory port onto a 32-bit generic_bus as 16 word beats.
// Latency: read line response 1 + 16*(busy stalls + 1) cycles after accept; writes end likewise, no response.
// Backpressure: one transaction at a time (mem_req_ready only in IDLE); bus busy stalls the current beat;
// the response is held stable until mem_rsp_ready.
// Ports: clk/reset (async active-high); mem_req_* Vortex request in; mem_rsp_* read
// response out; gbif initiator side of the generic bus.
module vx_mem_gbus_bridge
  import vx_gbus_bridge_pkg::*;
#(
  parameter int LINE_BITS = 512,
  parameter int ADDR_BITS = 26,
  parameter int TAG_BITS  = 56
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  input  logic                   mem_req_rw,
  input  logic [LINE_BITS/8-1:0] mem_req_byteen,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [LINE_BITS-1:0]   mem_req_data,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  output logic                   mem_req_ready,
  output logic                   mem_rsp_valid,
  output logic [LINE_BITS-1:0]   mem_rsp_data,
  output logic [TAG_BITS-1:0]    mem_rsp_tag,
  input  logic                   mem_rsp_ready,
  generic_bus_if.cpu             gbif
);

  state_e                 state_q, state_d;
  widx_t                  wcnt_q, wcnt_d;
  logic                   ld_q, ld_d;         // bus outputs hold word wcnt_q
  logic [LINE_BITS/8-1:0] be_q, be_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [LINE_BITS-1:0]   data_q, data_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic                   ren_q, ren_d;
  logic                   wen_q, wen_d;
  logic [31:0]            bus_addr_q, bus_addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             byte_en_q, byte_en_d;

  widx_t       nxt_w;
  widx_t       ld_w;
  logic        last_w;
  logic        do_load;
  logic [3:0]  ld_slice;
  logic [31:0] line_base;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    ld_d       = ld_q;
    be_d       = be_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tag_d      = tag_q;
    line_d     = line_q;
    ren_d      = ren_q;
    wen_d      = wen_q;
    bus_addr_d = bus_addr_q;
    wdata_d    = wdata_q;
    byte_en_d  = byte_en_q;
    do_load    = 1'b0;

    nxt_w     = wcnt_q + 1'b1;
    last_w    = (wcnt_q == widx_t'(WORDS_PER_LINE-1));
    line_base = 32'({addr_q, 6'b0});
    // First load of a write presents word wcnt_q; later loads present the next word.
    ld_w      = ld_q ? nxt_w : wcnt_q;
    ld_slice  = be_q[4*ld_w +: 4];

    case (state_q)
      IDLE: begin
        if (mem_req_valid) begin
          be_d    = mem_req_byteen;
          addr_d  = mem_req_addr;
          data_d  = mem_req_data;
          tag_d   = mem_req_tag;
          wcnt_d  = '0;
          ld_d    = 1'b0;
          state_d = mem_req_rw ? WRITE : READ;
        end
      end
      READ: begin
        if (!ld_q) begin
          ld_d       = 1'b1;
          ren_d      = 1'b1;
          wen_d      = 1'b0;
          byte_en_d  = 4'hF;
          bus_addr_d = line_base + word_offset(wcnt_q);
        end else if (ren_q && !gbif.busy) begin
          line_d[32*wcnt_q +: 32] = gbif.rdata;
          if (last_w) begin
            state_d = RSP;
            ren_d   = 1'b0;
            ld_d    = 1'b0;
          end else begin
            wcnt_d     = nxt_w;
            bus_addr_d = line_base + word_offset(nxt_w);
          end
        end
      end
      WRITE: begin
        if (!ld_q) begin
          do_load = 1'b1;
        end else if (!wen_q || !gbif.busy) begin
          // A zero byte-enable word spends exactly one cycle with wen low.
          if (last_w) begin
            state_d = IDLE;
            wen_d   = 1'b0;
            ld_d    = 1'b0;
          end else begin
            wcnt_d  = nxt_w;
            do_load = 1'b1;
          end
        end
      end
      RSP: begin
        if (mem_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      ld_d       = 1'b1;
      ren_d      = 1'b0;
      bus_addr_d = line_base + word_offset(ld_w);
      wdata_d    = data_q[32*ld_w +: 32];
      byte_en_d  = ld_slice;
      wen_d      = |ld_slice;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      ld_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      line_q     <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      bus_addr_q <= '0;
      wdata_q    <= '0;
      byte_en_q  <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      ld_q       <= ld_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      line_q     <= line_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      bus_addr_q <= bus_addr_d;
      wdata_q    <= wdata_d;
      byte_en_q  <= byte_en_d;
    end
  end

  assign mem_req_ready = (state_q == IDLE);
  assign mem_rsp_valid = (state_q == RSP);
  assign mem_rsp_data  = line_q;
  assign mem_rsp_tag   = tag_q;

  assign gbif.ren     = ren_q;
  assign gbif.wen     = wen_q;
  assign gbif.addr    = bus_addr_q;
  assign gbif.wdata   = wdata_q;
  assign gbif.byte_en = byte_en_q;

endmodule

// File: tb/tb_vx_mem_gbus_bridge.sv
// Scoreboard bench for vx_mem_gbus_bridge: stimulus pushes expected bus beats and
// line responses derived from the line/word rules; a negedge monitor pops and compares.
// Also acts as the generic_bus responder with a programmable busy stall per beat.
module tb_vx_mem_gbus_bridge;
  localparam int LB = 512;
  localparam int AB = 26;
  localparam int TB = 56;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            mem_req_valid = 1'b0;
  logic            mem_req_rw = 1'b0;
  logic [LB/8-1:0] mem_req_byteen = '0;
  logic [AB-1:0]   mem_req_addr = '0;
  logic [LB-1:0]   mem_req_data = '0;
  logic [TB-1:0]   mem_req_tag = '0;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [LB-1:0]   mem_rsp_data;
  logic [TB-1:0]   mem_rsp_tag;
  logic            mem_rsp_ready = 1'b0;

  generic_bus_if gbif();

  vx_mem_gbus_bridge #(.LINE_BITS(LB), .ADDR_BITS(AB), .TAG_BITS(TB)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready), .gbif(gbif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } beat_t;

  typedef struct {
    logic [LB-1:0] line;
    logic [TB-1:0] tag;
    int            rcyc;
  } rsp_t;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];

  // Responder: memory word at line index i returns rd_base + i.
  int          stall_n = 0;
  int          stall_cnt = 0;
  logic [31:0] rd_base = '0;
  logic        busy_r = 1'b0;
  assign gbif.busy  = busy_r;
  assign gbif.rdata = rd_base + ((gbif.addr >> 2) & 32'hF);

  int            ren_cyc = 0;
  int            rsp_vld_cyc = 0;
  logic          stall_prev = 1'b0;
  logic [69:0]   stall_snap = '0;
  logic          rsp_hold = 1'b0;
  logic [LB-1:0] hold_data = '0;
  logic [TB-1:0] hold_tag = '0;

  always @(negedge clk) begin
    beat_t e;
    rsp_t  r;
    if (stall_prev)
      check("bus_stable_busy", {gbif.ren, gbif.wen, gbif.byte_en, gbif.addr, gbif.wdata}, stall_snap);
    if (gbif.ren === 1'b1) ren_cyc++;
    if ((gbif.ren === 1'b1 || gbif.wen === 1'b1) && stall_cnt < stall_n) begin
      busy_r = 1'b1;
      stall_cnt++;
    end else begin
      busy_r = 1'b0;
      stall_cnt = 0;
    end
    stall_prev = busy_r;
    stall_snap = {gbif.ren, gbif.wen, gbif.byte_en, gbif.addr, gbif.wdata};

    if ((gbif.ren === 1'b1 || gbif.wen === 1'b1) && !busy_r) begin
      if (beat_q.size() == 0) begin
        check("beat_unexpected", {gbif.wen, gbif.addr}, 0);
      end else begin
        e = beat_q.pop_front();
        check("beat_wen", gbif.wen, e.wr);
        check("beat_ren", gbif.ren, !e.wr);
        check("beat_addr", gbif.addr, e.a);
        check("beat_byte_en", gbif.byte_en, e.be);
        if (e.wr) check("beat_wdata", gbif.wdata, e.d);
      end
    end

    if (mem_rsp_valid === 1'b1) begin
      rsp_vld_cyc++;
      check("req_ready_in_rsp", mem_req_ready, 0);
      if (rsp_hold) begin
        check("rsp_data_stable", mem_rsp_data, hold_data);
        check("rsp_tag_stable", mem_rsp_tag, hold_tag);
      end
      if (mem_rsp_ready) begin
        rsp_hold = 1'b0;
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", mem_rsp_tag, 0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_data", mem_rsp_data, r.line);
          check("rsp_tag", mem_rsp_tag, r.tag);
          check("rsp_ren_cycles", ren_cyc, r.rcyc);
        end
      end else begin
        rsp_hold  = 1'b1;
        hold_data = mem_rsp_data;
        hold_tag  = mem_rsp_tag;
      end
    end else begin
      rsp_hold = 1'b0;
    end
  end

  // Build the expected beats/response for one request straight from the line rules.
  task automatic expect_req(input bit rw, input logic [AB-1:0] a, input logic [LB-1:0] d,
                            input logic [LB/8-1:0] be, input logic [TB-1:0] t,
                            input int stall, input logic [31:0] rbase, output int lat);
    beat_t b;
    rsp_t  r;
    lat    = 1;
    r.line = '0;
    r.tag  = t;
    r.rcyc = 16 * (stall + 1);
    for (int i = 0; i < 16; i++) begin
      b.a  = ({6'b0, a} << 6) + 32'(4 * i);
      b.wr = rw;
      if (rw) begin
        b.d  = d[32*i +: 32];
        b.be = be[4*i +: 4];
        if (b.be != 4'h0) begin
          beat_q.push_back(b);
          lat += stall + 1;
        end else begin
          lat += 1;
        end
      end else begin
        b.d  = '0;
        b.be = 4'hF;
        beat_q.push_back(b);
        r.line[32*i +: 32] = rbase + 32'(i);
        lat += stall + 1;
      end
    end
    if (!rw) rsp_q.push_back(r);
  endtask

  task automatic drive_req(input bit rw, input logic [AB-1:0] a, input logic [LB-1:0] d,
                           input logic [LB/8-1:0] be, input logic [TB-1:0] t, output bit acc);
    int n = 0;
    acc = 1'b0;
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = a;
    mem_req_data   = d;
    mem_req_byteen = be;
    mem_req_tag    = t;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = mem_req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    mem_req_valid = 1'b0;
    mem_req_data  = {16{$urandom}};
    mem_req_tag   = {$urandom, $urandom};
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic issue(input bit rw, input logic [AB-1:0] a, input logic [LB-1:0] d,
                       input logic [LB/8-1:0] be, input logic [TB-1:0] t,
                       input int stall, input int hold, input logic [31:0] rbase);
    int lat;
    int n;
    int vbefore;
    bit acc;
    stall_n = stall;
    rd_base = rbase;
    expect_req(rw, a, d, be, t, stall, rbase, lat);
    ren_cyc = 0;
    vbefore = rsp_vld_cyc;
    drive_req(rw, a, d, be, t, acc);
    if (!acc) return;
    n = 0;
    if (!rw) begin
      while (mem_rsp_valid !== 1'b1 && n < 400) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("rsp_latency", n, lat);
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      mem_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      mem_rsp_ready = 1'b0;
    end else begin
      while (mem_req_ready !== 1'b1 && n < 400) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("wr_steps", n, lat);
      check("wr_no_rsp", rsp_vld_cyc - vbefore, 0);
    end
    check("beats_left", beat_q.size(), 0);
  endtask

  logic [LB-1:0]   dat;
  logic [LB/8-1:0] ben;

  initial begin
    int  lat;
    int  n;
    int  vb;
    bit  acc;

    #1 reset = 1'b1;
    #2;
    check("rst_req_ready", mem_req_ready, 1);
    check("rst_rsp_valid", mem_rsp_valid, 0);
    check("rst_ren_wen", {gbif.ren, gbif.wen}, 0);
    check("rst_byte_en", gbif.byte_en, 0);
    check("rst_addr", gbif.addr, 0);
    check("rst_wdata", gbif.wdata, 0);
    check("rst_rsp_data", mem_rsp_data, 0);
    check("rst_rsp_tag", mem_rsp_tag, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed read at line 0x10, no stalls, word i = 0xA0+i.
    issue(1'b0, 26'h000010, '0, '0, 56'h12_3456, 0, 0, 32'hA0);
    // Read with 3 busy cycles per beat.
    issue(1'b0, 26'h0ABCDE, '0, '0, 56'hBEEF, 3, 1, 32'h1000_0000);
    // Full write, word i = i.
    for (int i = 0; i < 16; i++) dat[32*i +: 32] = 32'(i);
    issue(1'b1, 26'h000020, dat, {64{1'b1}}, 56'h7, 0, 0, 0);
    // Sparse write: only words 0 and 3 enabled.
    issue(1'b1, 26'h000033, dat, 64'h000000000000F00F, 56'h8, 0, 0, 0);
    // Response held off for 5 cycles.
    issue(1'b0, 26'h3FFFFFF, '0, '0, 56'hFF_FFFF_FFFF_FFFF, 0, 5, 32'hFFFF_FFF0);

    // Reset asserted while word 7 of a read is on the bus.
    stall_n = 0;
    rd_base = 32'h55;
    expect_req(1'b0, 26'h000100, '0, '0, 56'h99, 0, 32'h55, lat);
    drive_req(1'b0, 26'h000100, '0, '0, 56'h99, acc);
    n = 0;
    while (!(gbif.ren === 1'b1 && gbif.addr == 32'h0000_401C) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_word7", gbif.addr, 32'h0000_401C);
    reset = 1'b1;
    #1;
    check("abort_ren", gbif.ren, 0);
    check("abort_req_ready", mem_req_ready, 1);
    @(posedge clk);
    #1;
    check("abort_edge_ren_wen", {gbif.ren, gbif.wen}, 0);
    check("abort_edge_req_ready", mem_req_ready, 1);
    beat_q.delete();
    rsp_q.delete();
    vb = rsp_vld_cyc;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_rsp", rsp_vld_cyc - vb, 0);

    // Randomized mix of reads and writes.
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 16; i++) begin
        dat[32*i +: 32] = $urandom;
        case ($urandom_range(0, 3))
          0:       ben[4*i +: 4] = 4'h0;
          1:       ben[4*i +: 4] = 4'hF;
          default: ben[4*i +: 4] = 4'($urandom_range(1, 15));
        endcase
      end
      issue(1'($urandom_range(0, 1)), 26'($urandom), dat, ben, {$urandom, $urandom},
            $urandom_range(0, 2), $urandom_range(0, 3), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
